// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter.
package seq_pattern_tx_pkg;

    // Transmitter FSM encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } tx_state_e;

    // Default pattern matches the team's 1101 sequence detectors.
    localparam int unsigned PAT_LEN_1101 = 4;
    localparam logic [PAT_LEN_1101-1:0] PATTERN_1101 = 4'b1101;

endpackage

// File: rtl/seq_bit_shifter.sv
// MSB-first pattern shifter. Zeros shift in behind the pattern, so once the
// last bit has gone out the serial output rests at 0 without extra gating.
module seq_bit_shifter
    import seq_pattern_tx_pkg::*;
#(
    parameter int unsigned          PAT_LEN = PAT_LEN_1101,
    parameter logic [PAT_LEN-1:0]   PATTERN = PATTERN_1101
) (
    input  logic clk,
    input  logic reset,
    input  logic load,   // present PATTERN MSB next cycle
    input  logic shift,  // advance to the next bit
    input  logic clear,  // drop any remaining bits
    output logic msb,    // bit currently on the line
    output logic last    // msb is the final pattern bit
);

    localparam int unsigned IdxW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] sr_q, sr_d;
    logic [IdxW-1:0]    idx_q, idx_d;

    // Next-state for the shift register and bit index; clear beats load beats shift.
    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (clear) begin
            sr_d  = '0;
            idx_d = '0;
        end else if (load) begin
            sr_d  = PATTERN;
            idx_d = IdxLast;
        end else if (shift) begin
            sr_d  = sr_q << 1;
            idx_d = (idx_q == '0) ? '0 : idx_q - IdxW'(1);
        end
    end

    // Shift register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign msb  = sr_q[PAT_LEN-1];
    assign last = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends rep_count copies of PATTERN, MSB first,
// separated by gap_len zero bits, then pulses done for one cycle.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int unsigned          PAT_LEN = PAT_LEN_1101,
    parameter logic [PAT_LEN-1:0]   PATTERN = PATTERN_1101,
    parameter int unsigned          CNT_W   = 8,
    parameter int unsigned          GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap_len,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] reps_sent
);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sh_load, sh_shift, sh_clear;
    logic             sh_msb, sh_last;

    seq_bit_shifter #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .clear (sh_clear),
        .msb   (sh_msb),
        .last  (sh_last)
    );

    // Next-state, counter updates and shifter control for the burst FSM.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        reps_d    = reps_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_clear  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    reps_d = '0;
                    if (rep_count == '0) begin
                        state_d = S_FIN;
                    end else begin
                        count_d = rep_count;
                        gap_d   = gap_len;
                        sh_load = 1'b1;
                        state_d = S_SEND;
                    end
                end
            end

            S_SEND: begin
                if (abort) begin
                    sh_clear = 1'b1;
                    state_d  = S_IDLE;
                end else if (sh_last) begin
                    reps_d = reps_q + CNT_W'(1);
                    if (reps_d == count_q) begin
                        sh_shift = 1'b1;
                        state_d  = S_FIN;
                    end else if (gap_q != '0) begin
                        // Shifting out the last bit leaves the line at 0 for the gap.
                        sh_shift  = 1'b1;
                        gap_cnt_d = gap_q;
                        state_d   = S_GAP;
                    end else begin
                        sh_load = 1'b1;
                    end
                end else begin
                    sh_shift = 1'b1;
                end
            end

            S_GAP: begin
                if (abort) begin
                    sh_clear = 1'b1;
                    state_d  = S_IDLE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    sh_load = 1'b1;
                    state_d = S_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                sh_clear = 1'b1;
                state_d  = S_IDLE;
            end
        endcase

        x_valid_d = (state_d == S_SEND) || (state_d == S_GAP);
        busy_d    = x_valid_d;
        done_d    = (state_d == S_FIN);
    end

    // FSM, counters and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            reps_q    <= '0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            reps_q    <= reps_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x         = sh_msb;
    assign x_valid   = x_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign reps_sent = reps_q;

endmodule
